// File: rtl/pid_pkg.sv
// Shared types and constants for the PID register-file writer.
package pid_pkg;

  localparam int D_WIDTH_DEF = 16;

  localparam int unsigned KP_ADDR = 0;
  localparam int unsigned KI_ADDR = 1;
  localparam int unsigned KD_ADDR = 2;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RUN   = 3'd1,
    PAUSE = 3'd2,
    WRITE = 3'd3,
    GAP   = 3'd4
  } state_e;

endpackage

// File: rtl/pid_wr_fifo.sv
// Pending-write FIFO: each entry holds one {addr, data} register write.
module pid_wr_fifo #(
  parameter int D_WIDTH    = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               push_i,
  input  logic [D_WIDTH-1:0] push_addr_i,
  input  logic [D_WIDTH-1:0] push_data_i,
  input  logic               pop_i,
  output logic [D_WIDTH-1:0] pop_addr_o,
  output logic [D_WIDTH-1:0] pop_data_o,
  output logic               full_o,
  output logic               empty_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

  logic [2*D_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [AW:0]          wptr_q, rptr_q;
  logic                 do_push, do_pop;

  // Pointers carry one extra wrap bit to tell full from empty.
  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + PTR_ONE;
      if (do_pop)  rptr_q <= rptr_q + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q[AW-1:0]] <= {push_addr_i, push_data_i};
  end

  assign {pop_addr_o, pop_data_o} = mem_q[rptr_q[AW-1:0]];

endmodule

// File: rtl/pid_reg_writer.sv
// Queues host register writes and applies them to the PID register file
// only while the PID is not iterating, pausing it at an iteration boundary.
module pid_reg_writer
  import pid_pkg::*;
#(
  parameter int D_WIDTH    = D_WIDTH_DEF,
  parameter int FIFO_DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [D_WIDTH-1:0] req_addr,
  input  logic [D_WIDTH-1:0] req_data,
  input  logic               run_req,
  input  logic               pid_out_valid,
  output logic               write_enable,
  output logic [D_WIDTH-1:0] reg_addr,
  output logic [D_WIDTH-1:0] reg_data,
  output logic               iterate_enable,
  output logic               busy,
  output logic [D_WIDTH-1:0] wr_count
);

  state_e             state_q, state_d;
  logic               we_q, ie_q;
  logic [D_WIDTH-1:0] addr_q, data_q, cnt_q;
  logic               full, empty, push, pop;
  logic [D_WIDTH-1:0] head_addr, head_data;

  assign req_ready = !full && !rst;
  assign push      = req_valid && req_ready;
  // An entry leaves the FIFO on exactly the edge its strobe is registered.
  assign pop       = (state_d == WRITE);

  pid_wr_fifo #(
    .D_WIDTH    (D_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (push),
    .push_addr_i (req_addr),
    .push_data_i (req_data),
    .pop_i       (pop),
    .pop_addr_o  (head_addr),
    .pop_data_o  (head_data),
    .full_o      (full),
    .empty_o     (empty)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (!empty) state_d = WRITE;
               else if (run_req) state_d = RUN;
      RUN:     if (!run_req) state_d = IDLE;
               else if (!empty) state_d = PAUSE;
      PAUSE:   if (!run_req || pid_out_valid) state_d = WRITE;
      WRITE:   if (empty) state_d = GAP;
      GAP:     if (!empty) state_d = WRITE;
               else if (run_req) state_d = RUN;
               else state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      we_q    <= 1'b1;
      ie_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      we_q    <= !pop;
      ie_q    <= (state_d == RUN) || (state_d == PAUSE);
      if (pop) begin
        addr_q <= head_addr;
        data_q <= head_data;
      end
      if (!we_q) cnt_q <= cnt_q + D_WIDTH'(1);
    end
  end

  assign write_enable   = we_q;
  assign iterate_enable = ie_q;
  assign reg_addr       = addr_q;
  assign reg_data       = data_q;
  assign wr_count       = cnt_q;
  assign busy           = !empty || !(state_q inside {IDLE, RUN});

endmodule
